assist_mult_seq: RTL and testbench

Multi-cycle sequencer for the assist-current calculation. A single shared 15x15 multiplier is time-multiplexed across the three products: torque*scale, incline*cadence, and their product. A start/done handshake replaces the fully pipelined three-multiplier datapath. It sits between the sensor-conditioning logic (avg torque, cadence, incline) and the PID/current loop, and is started once per control period.

---
 rtl/assist_mult_seq_if.sv | 23 ++
 rtl/assist_mult_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_assist_mult_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/assist_mult_seq_if.sv
// assist_mult_seq_if: request/operand/result bundle between the sensor
// conditioning logic (master) and the assist-current sequencer (slave).
interface assist_mult_seq_if;
    logic        start;
    logic [11:0] avg_torque;
    logic [4:0]  cadence;
    logic        not_pedaling;
    logic [12:0] incline;
    logic [2:0]  scale;
    logic        busy;
    logic        done;
    logic [11:0] target_curr;

    modport master (
        output start, avg_torque, cadence, not_pedaling, incline, scale,
        input  busy, done, target_curr
    );

    modport slave (
        input  start, avg_torque, cadence, not_pedaling, incline, scale,
        output busy, done, target_curr
    );
endinterface

// File: rtl/assist_mult_seq.sv
// assist_mult_seq: multi-cycle assist-current sequencer. One shared 15x15
// multiplier is time-multiplexed over torque*scale, incline*cadence and the
// product of the two, then the result is saturated into a 12-bit target
// current. A start/done handshake frames each computation.
//
// Optional build macro ASSIST_EARLY_OUT_EN: when defined, a computation whose
// result is known to be zero after the captured operands are evaluated
// (not pedaling, no positive torque, or cadence factor 0) skips straight from
// MUL1 to SAT, giving a 2-cycle latency instead of 4.
module assist_mult_seq #(
    parameter logic [11:0] TORQUE_MIN = 12'h380,
    parameter int unsigned CAD_OFF    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    assist_mult_seq_if.slave  bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL1 = 3'd1;
    localparam logic [2:0] MUL2 = 3'd2;
    localparam logic [2:0] MUL3 = 3'd3;
    localparam logic [2:0] SAT  = 3'd4;

    localparam logic [5:0] CAD_OFF_W = 6'(CAD_OFF);

    // Saturate the 30-bit Q15 product to the 12-bit current range.
    function automatic logic [11:0] sat_curr(input logic [29:0] p);
        logic [11:0] r;
        if (|p[29:27]) begin
            r = 12'hFFF;
        end else begin
            r = p[26:15];
        end
        return r;
    endfunction

    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        busy_r;
    logic        done_r;
    logic [11:0] target_r;

    logic [11:0] torque_r;
    logic [4:0]  cad_r;
    logic        np_r;
    logic [12:0] incline_r;
    logic [2:0]  scale_r;

    logic [14:0] prod_a_r;
    logic [14:0] prod_b_r;
    logic [29:0] prod_p_r;

    logic [12:0] torque_diff_s;
    logic [11:0] torque_pos_s;
    logic [9:0]  incline_sat_s;
    logic [10:0] incline_factor_s;
    logic [8:0]  incline_lim_s;
    logic [5:0]  cadence_factor_s;
    logic [14:0] mul_a_s;
    logic [14:0] mul_b_s;
    logic [29:0] mul_out_s;
`ifdef ASSIST_EARLY_OUT_EN
    logic        early_out_s;
`endif

    // Positive part of the torque above the pedaling threshold.
    always_comb begin
        torque_diff_s = {1'b0, torque_r} - {1'b0, TORQUE_MIN};
        if (torque_diff_s[12]) begin
            torque_pos_s = 12'h000;
        end else begin
            torque_pos_s = torque_diff_s[11:0];
        end
    end

    // Incline clamp to 10b signed, bias by +256, then clamp to 0..511.
    always_comb begin
        if ($signed(incline_r) > 13'sd511) begin
            incline_sat_s = 10'h1FF;
        end else if ($signed(incline_r) < -13'sd512) begin
            incline_sat_s = 10'h200;
        end else begin
            incline_sat_s = incline_r[9:0];
        end
        incline_factor_s = {incline_sat_s[9], incline_sat_s} + 11'd256;
        if (incline_factor_s[10]) begin
            incline_lim_s = 9'd0;
        end else if (incline_factor_s[9]) begin
            incline_lim_s = 9'd511;
        end else begin
            incline_lim_s = incline_factor_s[8:0];
        end
    end

    // Cadence contributes only once the rider is actually turning the cranks.
    always_comb begin
        if (cad_r > 5'd1) begin
            cadence_factor_s = {1'b0, cad_r} + CAD_OFF_W;
        end else begin
            cadence_factor_s = 6'd0;
        end
    end

`ifdef ASSIST_EARLY_OUT_EN
    // Result is provably zero: skip the remaining multiplies.
    always_comb begin
        early_out_s = np_r | (torque_pos_s == 12'h000) | (cadence_factor_s == 6'd0);
    end
`endif

    // Operand mux for the single shared multiplier, selected by state.
    always_comb begin
        mul_a_s = 15'd0;
        mul_b_s = 15'd0;
        case (state_r)
            MUL1: begin
                mul_a_s = {3'd0, torque_pos_s};
                mul_b_s = {12'd0, scale_r};
            end
            MUL2: begin
                mul_a_s = {6'd0, incline_lim_s};
                mul_b_s = {9'd0, cadence_factor_s};
            end
            MUL3: begin
                mul_a_s = prod_a_r;
                mul_b_s = prod_b_r;
            end
            default: begin
                mul_a_s = 15'd0;
                mul_b_s = 15'd0;
            end
        endcase
        mul_out_s = {15'd0, mul_a_s} * {15'd0, mul_b_s};
    end

    // Next-state decode for the sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = MUL1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
`ifdef ASSIST_EARLY_OUT_EN
            MUL1: begin
                if (early_out_s) begin
                    state_nxt_s = SAT;
                end else begin
                    state_nxt_s = MUL2;
                end
            end
`else
            MUL1:    state_nxt_s = MUL2;
`endif
            MUL2:    state_nxt_s = MUL3;
            MUL3:    state_nxt_s = SAT;
            SAT:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    // Capture all operands on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            torque_r  <= 12'h000;
            cad_r     <= 5'd0;
            np_r      <= 1'b0;
            incline_r <= 13'h0000;
            scale_r   <= 3'd0;
        end else if ((state_r == IDLE) && bus.start) begin
            torque_r  <= bus.avg_torque;
            cad_r     <= bus.cadence;
            np_r      <= bus.not_pedaling;
            incline_r <= bus.incline;
            scale_r   <= bus.scale;
        end
    end

    // Intermediate product registers, each loaded in its own multiply state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_a_r <= 15'd0;
            prod_b_r <= 15'd0;
            prod_p_r <= 30'd0;
        end else begin
            case (state_r)
                MUL1: begin
                    prod_a_r <= mul_out_s[14:0];
`ifdef ASSIST_EARLY_OUT_EN
                    if (early_out_s) begin
                        prod_p_r <= 30'd0;
                    end
`endif
                end
                MUL2:    prod_b_r <= mul_out_s[14:0];
                MUL3:    prod_p_r <= mul_out_s;
                default: prod_p_r <= prod_p_r;
            endcase
        end
    end

    // Result register and one-cycle done pulse; result held until next SAT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_r <= 12'h000;
            done_r   <= 1'b0;
        end else begin
            done_r <= (state_r == SAT);
            if (state_r == SAT) begin
                target_r <= np_r ? 12'h000 : sat_curr(prod_p_r);
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.target_curr = target_r;

endmodule

// File: tb/tb_assist_mult_seq.sv
// Self-checking bench for assist_mult_seq: directed vectors push expected
// results into a scoreboard; a monitor pops and compares on every done pulse.
module tb_assist_mult_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    assist_mult_seq_if bus();

    assist_mult_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef ASSIST_EARLY_OUT_EN
    localparam int LAT_Z = 2;
`else
    localparam int LAT_Z = 4;
`endif

    typedef struct {
        logic [11:0] val;
        int          sedge;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected none (target_curr=%0h, cycle %0d)",
                         bus.target_curr, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_value"}, bus.target_curr, mon_e.val);
                check({mon_e.name, "_latency"}, cyc - mon_e.sedge, mon_e.lat);
                check({mon_e.name, "_busy_in_done"}, bus.busy, 1'b0);
            end
        end
    end

    task automatic push_exp(input string name, input logic [11:0] val, input int sedge, input int lat);
        exp_t e;
        e.val = val; e.sedge = sedge; e.lat = lat; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [11:0] t, input logic [4:0] c, input logic np,
                         input logic [12:0] inc, input logic [2:0] s);
        bus.avg_torque = t; bus.cadence = c; bus.not_pedaling = np;
        bus.incline = inc; bus.scale = s;
    endtask

    task automatic scramble();
        bus.avg_torque   = 12'($urandom);
        bus.cadence      = 5'($urandom);
        bus.not_pedaling = 1'($urandom);
        bus.incline      = 13'($urandom);
        bus.scale        = 3'($urandom);
    endtask

    // One-cycle start pulse; returns at the negedge after the sampling edge.
    task automatic issue(input string name, input logic [11:0] t, input logic [4:0] c,
                         input logic np, input logic [12:0] inc, input logic [2:0] s,
                         input logic [11:0] exp, input int lat);
        @(negedge clk);
        drive(t, c, np, inc, s);
        bus.start = 1'b1;
        push_exp(name, exp, cyc + 1, lat);
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run_vec(input string name, input logic [11:0] t, input logic [4:0] c,
                           input logic np, input logic [12:0] inc, input logic [2:0] s,
                           input logic [11:0] exp, input int lat);
        issue(name, t, c, np, inc, s, exp, lat);
        wait_drain(name);
    endtask

    initial begin
        bus.start = 1'b0;
        drive(12'h000, 5'd0, 1'b0, 13'h0000, 3'd0);
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_target", bus.target_curr, 12'h000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal with busy profile: high for exactly 4 cycles after the start edge.
        issue("nominal", 12'h700, 5'd10, 1'b0, 13'h0000, 3'd3, 12'h372, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nominal_busy%0d", i), bus.busy, 1'b1);
            @(negedge clk);
        end
        check("nominal_busy_end", bus.busy, 1'b0);
        wait_drain("nominal");

        run_vec("saturate",    12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7, 12'hFFF, 4);
        run_vec("incline_p100", 12'h500, 5'd10, 1'b0, 13'h0064, 3'd2, 12'h15E, 4);
        run_vec("incline_m100", 12'h700, 5'd10, 1'b0, 13'h1F9C, 3'd3, 12'h219, 4);
        run_vec("incline_p300", 12'h480, 5'd20, 1'b0, 13'h012C, 3'd4, 12'h33E, 4);
        run_vec("cadence2",    12'h700, 5'd2,  1'b0, 13'h0000, 3'd3, 12'h2CA, 4);
        run_vec("incline_m300", 12'h700, 5'd10, 1'b0, 13'h1ED4, 3'd3, 12'h000, 4);
        run_vec("incline_min", 12'h700, 5'd10, 1'b0, 13'h1000, 3'd3, 12'h000, 4);
        run_vec("scale0",      12'h700, 5'd10, 1'b0, 13'h0000, 3'd0, 12'h000, 4);
        run_vec("cadence1",    12'h700, 5'd1,  1'b0, 13'h0000, 3'd3, 12'h000, LAT_Z);
        run_vec("cadence0",    12'h700, 5'd0,  1'b0, 13'h0000, 3'd3, 12'h000, LAT_Z);
        run_vec("torque_low",  12'h200, 5'd10, 1'b0, 13'h0000, 3'd3, 12'h000, LAT_Z);
        run_vec("torque_min",  12'h380, 5'd10, 1'b0, 13'h0000, 3'd3, 12'h000, LAT_Z);
        run_vec("not_pedal",   12'hFFF, 5'd31, 1'b1, 13'h0FFF, 3'd7, 12'h000, LAT_Z);

        // Start re-asserted during MUL2 with other inputs: ignored.
        issue("busy_prot", 12'h500, 5'd10, 1'b0, 13'h0064, 3'd2, 12'h15E, 4);
        @(negedge clk);
        drive(12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain("busy_prot");
        repeat (8) @(negedge clk);

        // Start held high: a result every 5 clocks.
        @(negedge clk);
        drive(12'h700, 5'd10, 1'b0, 13'h0000, 3'd3);
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) push_exp($sformatf("b2b%0d", k), 12'h372, cyc + 1 + 5 * k, 4);
        repeat (15) @(negedge clk);
        bus.start = 1'b0;
        wait_drain("b2b");
        repeat (6) @(negedge clk);

        // Reset during MUL3 aborts the computation with no done.
        @(negedge clk);
        drive(12'hFFF, 5'd31, 1'b0, 13'h0FFF, 3'd7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_busy_before", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midop_busy", bus.busy, 1'b0);
        check("midop_done", bus.done, 1'b0);
        check("midop_target", bus.target_curr, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        run_vec("after_reset", 12'h700, 5'd10, 1'b0, 13'h0000, 3'd3, 12'h372, 4);

        // Hold: inputs toggle without start; result and done must stay put.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            scramble();
        end
        check("hold_target", bus.target_curr, 12'h372);
        check("hold_busy", bus.busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
